// File: rtl/mont_result_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// mont_result_buffer: two-bank ping-pong capture/replay of results
// Revision: 1.0
// ------------------------------------------------------------------
module mont_result_buffer #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096,
  parameter int NUM_BLOCKS    = BITS_IN_NUM / REGISTER_SIZE
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] data_in,
  input  logic                     valid_in,
  input  logic                     ready_in,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  output logic                     last_out,
  output logic                     can_accept_out,
  output logic                     overflow_out,
  output logic [1:0]               results_stored_out
);

  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  bank_state_t [1:0] state_q;
  bank_state_t [1:0] state_d;

  logic [REGISTER_SIZE-1:0] mem [0:2*NUM_BLOCKS-1];

  logic             wb;
  logic             rb;
  logic [IDX_W-1:0] wi;
  logic [CNT_W-1:0] fcnt;
  logic             armed;

  logic wr_en;
  logic wr_last;
  logic fetch_en;
  logic drain_done;

  assign wr_en      = valid_in && (state_q[wb] inside {EMPTY, FILLING});
  assign wr_last    = (wi == IDX_W'(NUM_BLOCKS - 1));
  // armed lags the bank becoming FULL by one edge, which fixes the
  // two-edge gap between the final write and the first presented word.
  assign fetch_en   = armed && (fcnt != CNT_W'(NUM_BLOCKS)) && (!valid_out || ready_in);
  assign drain_done = valid_out && ready_in && last_out;

  assign can_accept_out     = state_q[wb] inside {EMPTY, FILLING};
  assign results_stored_out = {1'b0, state_q[0] inside {FULL, DRAINING}}
                            + {1'b0, state_q[1] inside {FULL, DRAINING}};

  // Write and read never target the same bank in one cycle, so both
  // updates can be applied independently.
  always_comb begin
    state_d = state_q;
    if (wr_en) begin
      state_d[wb] = wr_last ? FULL : FILLING;
    end
    if (fetch_en && (state_q[rb] == FULL)) begin
      state_d[rb] = DRAINING;
    end
    if (drain_done) begin
      state_d[rb] = EMPTY;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[{wb, wi}] <= data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q[0]   <= EMPTY;
      state_q[1]   <= EMPTY;
      wb           <= 1'b0;
      rb           <= 1'b0;
      wi           <= '0;
      fcnt         <= '0;
      armed        <= 1'b0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      last_out     <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      state_q <= state_d;

      if (wr_en) begin
        if (wr_last) begin
          wi <= '0;
          wb <= ~wb;
        end else begin
          wi <= wi + IDX_W'(1);
        end
      end else if (valid_in) begin
        overflow_out <= 1'b1;
      end

      armed <= !drain_done && (state_q[rb] inside {FULL, DRAINING});

      if (fetch_en) begin
        data_out  <= mem[{rb, fcnt[IDX_W-1:0]}];
        last_out  <= (fcnt == CNT_W'(NUM_BLOCKS - 1));
        valid_out <= 1'b1;
        fcnt      <= fcnt + CNT_W'(1);
      end else if (ready_in) begin
        valid_out <= 1'b0;
        last_out  <= 1'b0;
      end

      if (drain_done) begin
        fcnt <= '0;
        rb   <= ~rb;
      end
    end
  end

endmodule
`default_nettype wire
